// File: rtl/gpu_timing_pkg.sv
// Shared timing definitions for the FSX GPU video path: mode constant sets
// and the width helper used to size counters from segment lengths.
package gpu_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
    logic [7:0]  xscale;
    logic [7:0]  yscale;
    logic [15:0] fetch_lead;
  } timing_mode_t;

  // 640x480@60, 2x2 source pixels (320x240 source)
  localparam timing_mode_t VGA_640x480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0, xscale: 8'd2, yscale: 8'd2, fetch_lead: 16'd16
  };

  // Wide 240-line mode, 4x horizontal scale. Active width is trimmed to
  // 1704 so it divides evenly into 426 source columns.
  localparam timing_mode_t WIDE_1706x240 = '{
    h_active: 16'd1704, h_fp: 16'd32, h_sync: 16'd88, h_bp: 16'd112,
    v_active: 16'd240,  v_fp: 16'd3,  v_sync: 16'd3,  v_bp: 16'd16,
    h_pol: 1'b1, v_pol: 1'b1, xscale: 8'd4, yscale: 8'd1, fetch_lead: 16'd32
  };

  // Bits needed to hold 0..n-1, never less than one bit
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/video_timing_gen_scaled_counter.sv
// Position counter with a prescaled companion counter (position / SCALE),
// so the source coordinate needs no divider. Exposes its next-state values
// so the owner can register outputs aligned with the new position.
module scaled_counter
  import gpu_timing_pkg::*;
#(
  parameter int TOTAL  = 16,
  parameter int ACTIVE = 8,
  parameter int SCALE  = 2,
  parameter int CW     = clog2w(TOTAL),
  parameter int SW     = clog2w(ACTIVE / SCALE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_hold,         // freeze everything
  input  logic          i_clr,          // synchronous return to position 0
  input  logic          i_step,         // advance one position this cycle
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_nxt,
  output logic [SW-1:0] o_scl_nxt,      // next scaled position (0 outside active)
  output logic          o_pre_last_nxt, // next position is last of its source unit
  output logic          o_wrap          // this cycle wraps TOTAL-1 -> 0
);

  localparam int PW = clog2w(SCALE);

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scl;
  logic [PW-1:0] w_pre_nxt;
  logic          w_adv;

  // Next position, prescaler and scaled value
  always_comb begin
    w_adv          = i_step & ~i_hold;
    o_wrap         = w_adv & ~i_clr & (int'(r_cnt) == TOTAL - 1);
    o_nxt          = r_cnt;
    w_pre_nxt      = r_pre;
    o_scl_nxt      = r_scl;
    if (i_clr) begin
      o_nxt     = '0;
      w_pre_nxt = '0;
      o_scl_nxt = '0;
    end else if (w_adv) begin
      o_nxt = o_wrap ? '0 : r_cnt + 1'b1;
      // Scaling restarts at position 0 and parks at 0 outside the active span
      if ((int'(o_nxt) >= ACTIVE) || (o_nxt == '0)) begin
        w_pre_nxt = '0;
        o_scl_nxt = '0;
      end else if (int'(r_pre) == SCALE - 1) begin
        w_pre_nxt = '0;
        o_scl_nxt = r_scl + 1'b1;
      end else begin
        w_pre_nxt = r_pre + 1'b1;
      end
    end
    o_pre_last_nxt = (int'(w_pre_nxt) == SCALE - 1);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pre <= '0;
      r_scl <= '0;
    end else begin
      r_cnt <= o_nxt;
      r_pre <= w_pre_nxt;
      r_scl <= o_scl_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised pixel-clock video timing generator: counters, syncs, blank,
// scaled source coordinates, line prefetch request and frameDrawn interrupt.
// Every output is registered from the next counter state, so all outputs
// describe the same (hcount, vcount) they are presented with.
module video_timing_gen
  import gpu_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = int'(VGA_640x480.h_active),
  parameter int   H_FP       = int'(VGA_640x480.h_fp),
  parameter int   H_SYNC     = int'(VGA_640x480.h_sync),
  parameter int   H_BP       = int'(VGA_640x480.h_bp),
  parameter int   V_ACTIVE   = int'(VGA_640x480.v_active),
  parameter int   V_FP       = int'(VGA_640x480.v_fp),
  parameter int   V_SYNC     = int'(VGA_640x480.v_sync),
  parameter int   V_BP       = int'(VGA_640x480.v_bp),
  parameter logic H_POL      = VGA_640x480.h_pol,
  parameter logic V_POL      = VGA_640x480.v_pol,
  parameter int   XSCALE     = int'(VGA_640x480.xscale),
  parameter int   YSCALE     = int'(VGA_640x480.yscale),
  parameter int   FETCH_LEAD = int'(VGA_640x480.fetch_lead),
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW         = clog2w(H_TOTAL),
  localparam int  VW         = clog2w(V_TOTAL),
  localparam int  XW         = clog2w(H_ACTIVE / XSCALE),
  localparam int  YW         = clog2w(V_ACTIVE / YSCALE)
) (
  input  logic          clkPixel,
  input  logic          nreset,
  input  logic          enable,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          fetch_req,
  output logic [YW-1:0] fetch_line,
  output logic          frameDrawn
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int FETCH_H  = H_TOTAL - FETCH_LEAD;

  logic [HW-1:0] w_hnxt;
  logic [VW-1:0] w_vnxt;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_hwrap, w_vwrap;
  logic          w_hpre_last, w_vpre_last;
  logic          w_hsync_n, w_vsync_n, w_blank_n;
  logic          w_fetch_n, w_frame_n;
  logic [YW-1:0] w_fetch_line_n;
  logic          w_unused;

  logic          r_hsync, r_vsync, r_blank;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_fetch_req, r_frame;
  logic [YW-1:0] r_fetch_line;

  scaled_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SCALE(XSCALE), .CW(HW), .SW(XW)
  ) u_hcnt (
    .clk(clkPixel), .rst_n(nreset), .i_hold(~enable), .i_clr(1'b0),
    .i_step(1'b1), .o_cnt(hcount), .o_nxt(w_hnxt), .o_scl_nxt(w_x_nxt),
    .o_pre_last_nxt(w_hpre_last), .o_wrap(w_hwrap)
  );

  scaled_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SCALE(YSCALE), .CW(VW), .SW(YW)
  ) u_vcnt (
    .clk(clkPixel), .rst_n(nreset), .i_hold(~enable), .i_clr(1'b0),
    .i_step(w_hwrap), .o_cnt(vcount), .o_nxt(w_vnxt), .o_scl_nxt(w_y_nxt),
    .o_pre_last_nxt(w_vpre_last), .o_wrap(w_vwrap)
  );

  assign w_unused = &{1'b0, w_hpre_last, w_vwrap};

  // Output values for the position the counters move to this cycle
  always_comb begin
    w_hsync_n = (int'(w_hnxt) >= HS_START) && (int'(w_hnxt) < HS_END);
    w_vsync_n = (int'(w_vnxt) >= VS_START) && (int'(w_vnxt) < VS_END);
    w_blank_n = (int'(w_hnxt) >= H_ACTIVE) || (int'(w_vnxt) >= V_ACTIVE);
    w_frame_n = (w_hnxt == '0) && (int'(w_vnxt) == V_ACTIVE);
    // Fetch targets the line after the next one; the last blank line
    // fetches source line 0, otherwise the next line must open a new
    // source line, i.e. the current one closes its source unit.
    w_fetch_n      = 1'b0;
    w_fetch_line_n = '0;
    if (int'(w_hnxt) == FETCH_H) begin
      if (int'(w_vnxt) == V_TOTAL - 1) begin
        w_fetch_n = 1'b1;
      end else if ((int'(w_vnxt) < V_ACTIVE - 1) && w_vpre_last) begin
        w_fetch_n      = 1'b1;
        w_fetch_line_n = w_y_nxt + 1'b1;
      end
    end
  end

  // Registered outputs; pulses clear and everything else holds when frozen
  always_ff @(posedge clkPixel or negedge nreset) begin
    if (!nreset) begin
      r_hsync      <= ~H_POL;
      r_vsync      <= ~V_POL;
      r_blank      <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_fetch_req  <= 1'b0;
      r_fetch_line <= '0;
      r_frame      <= 1'b0;
    end else if (enable) begin
      r_hsync     <= w_hsync_n ? H_POL : ~H_POL;
      r_vsync     <= w_vsync_n ? V_POL : ~V_POL;
      r_blank     <= w_blank_n;
      r_x         <= w_blank_n ? '0 : w_x_nxt;
      r_y         <= w_blank_n ? '0 : w_y_nxt;
      r_fetch_req <= w_fetch_n;
      r_frame     <= w_frame_n;
      if (w_fetch_n) r_fetch_line <= w_fetch_line_n;
    end else begin
      r_fetch_req <= 1'b0;
      r_frame     <= 1'b0;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign blank      = r_blank;
  assign x          = r_x;
  assign y          = r_y;
  assign fetch_req  = r_fetch_req;
  assign fetch_line = r_fetch_line;
  assign frameDrawn = r_frame;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small 16x8 mode. A behavioural model
// derives the expected position from the count of enabled cycles since
// reset and evaluates the output rules arithmetically every cycle.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 4;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XS = 2, YS = 2, FL = 3;
  localparam logic HP = 1'b1, VP = 1'b0;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b1;
  logic [3:0] hcount;
  logic [2:0] vcount;
  logic       hsync, vsync, blank, fetch_req, frameDrawn;
  logic [1:0] x;
  logic [0:0] y, fetch_line;

  int   errors = 0;
  int   checks = 0;
  int   t = 0;
  logic last_en = 1'b1;
  bit   run_chk = 1'b0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .XSCALE(XS), .YSCALE(YS), .FETCH_LEAD(FL)
  ) dut (
    .clkPixel(clk), .nreset(nrst), .enable(en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .blank(blank), .x(x), .y(y), .fetch_req(fetch_req),
    .fetch_line(fetch_line), .frameDrawn(frameDrawn)
  );

  always #5 clk = ~clk;

  // Model state: enabled cycles since reset, and whether the last edge advanced
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      t       <= 0;
      last_en <= 1'b1;
    end else begin
      if (en) t <= t + 1;
      last_en <= en;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, t);
    end
  endtask

  // Per-cycle comparison against the rule-based model
  always @(negedge clk) begin : cmp
    int h, v, n, ex, ey, efl;
    logic eh, ev, eb, ef, efd;
    if (run_chk) begin
      h   = t % HT;
      v   = (t / HT) % VT;
      n   = (v + 1) % VT;
      eh  = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
      ev  = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
      eb  = (h >= HA) || (v >= VA);
      ex  = eb ? 0 : h / XS;
      ey  = eb ? 0 : v / YS;
      ef  = last_en && (h == HT - FL) && (n < VA) && (n % YS == 0);
      efl = n / YS;
      efd = last_en && (h == 0) && (v == VA);
      chk("hcount", hcount, h);
      chk("vcount", vcount, v);
      chk("hsync", hsync, eh);
      chk("vsync", vsync, ev);
      chk("blank", blank, eb);
      chk("x", x, ex);
      chk("y", y, ey);
      chk("fetch_req", fetch_req, ef);
      if (ef) chk("fetch_line", fetch_line, efl);
      chk("frameDrawn", frameDrawn, efd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (t != target && n < 2000) begin
      tick();
      n++;
    end
    if (t != target) begin
      checks++;
      errors++;
      $display("FAIL run_to: reached t=%0d expected %0d", t, target);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int xt [8];
    xt = '{0, 0, 1, 1, 2, 2, 3, 3};

    // Reset state
    tick(); tick();
    chk("rst_hcount", hcount, 0);
    chk("rst_vcount", vcount, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 1);
    chk("rst_blank", blank, 0);
    chk("rst_fetch", fetch_req, 0);
    chk("rst_frame", frameDrawn, 0);
    run_chk = 1'b1;
    nrst = 1'b1;
    tick();
    chk("first_edge_h", hcount, 1);
    chk("first_edge_v", vcount, 0);

    // Prefetch of source line 1 on vcount 1
    run_to(1 * HT + 13);
    chk("fetch1_req", fetch_req, 1);
    chk("fetch1_line", fetch_line, 1);

    // Scaling across row 3
    for (int i = 0; i < 8; i++) begin
      run_to(3 * HT + i);
      chk("x_row3", x, xt[i]);
      chk("y_row3", y, 1);
    end
    for (int i = 8; i < 16; i++) begin
      run_to(3 * HT + i);
      chk("x_hblank", x, 0);
    end

    run_to(4 * HT);
    chk("frame_pulse", frameDrawn, 1);
    run_to(4 * HT + 1);
    chk("frame_single", frameDrawn, 0);

    // Prefetch of source line 0 during the last blank line
    run_to(7 * HT + 13);
    chk("fetch0_req", fetch_req, 1);
    chk("fetch0_line", fetch_line, 0);
    chk("fetch0_v", vcount, 7);
    run_to(128);
    chk("period_h", hcount, 0);
    chk("period_v", vcount, 0);

    // Freeze at (13,1) for 5 cycles
    run_to(128 + HT + 13);
    chk("frz_fetch_pre", fetch_req, 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_h", hcount, 13);
      chk("frz_v", vcount, 1);
      chk("frz_fetch", fetch_req, 0);
      chk("frz_blank", blank, 1);
    end
    en = 1'b1;
    tick();
    chk("resume_h", hcount, 14);
    chk("resume_fetch", fetch_req, 0);

    run_to(128 + 4 * HT);
    chk("frame_pulse2", frameDrawn, 1);

    // Reset mid-frame at (11,5)
    run_to(256 + 5 * HT + 11);
    chk("pre_rst_h", hcount, 11);
    chk("pre_rst_hsync", hsync, 1);
    chk("pre_rst_vsync", vsync, 0);
    nrst = 1'b0;
    #1;
    chk("mid_rst_h", hcount, 0);
    chk("mid_rst_v", vcount, 0);
    chk("mid_rst_hsync", hsync, 0);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_blank", blank, 0);
    tick();
    nrst = 1'b1;
    tick();
    chk("post_rst_h", hcount, 1);
    chk("post_rst_v", vcount, 0);

    // Randomised enable with occasional short resets
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 399) == 0) begin
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
      end
    end
    en = 1'b1;
    tick();
    run_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
